// File: rtl/psram_argmax.sv
// psram_argmax: reads NUM_CLASSES packed 8-bit probabilities from PSRAM one
// 32-bit word at a time, scans them one byte per cycle and reports the index
// and value of the largest one, plus a threshold detection flag.
//
// Memory handshake: mem_start is held high for the whole REQ state and is a
// pure function of the state register. The controller completes the read by
// raising mem_done for one cycle, with mem_rdata valid in that cycle. The FSM
// leaves REQ on that same edge, so mem_start is low in the following cycle.
// A mem_done seen in any other state is ignored.
`timescale 1ns/1ps
module psram_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int PROB_BITS   = 8,
  parameter int ADDR_WIDTH  = 24,
  parameter int IDX_BITS    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [PROB_BITS-1:0]  threshold,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_size,
  output logic                  mem_start,
  input  logic                  mem_done,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_BITS-1:0]   class_idx,
  output logic [PROB_BITS-1:0]  class_prob,
  output logic                  detected,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // The class counter doubles as word counter (upper bits) and byte counter (low 2 bits).
  localparam int         CNT_W    = 7;
  localparam logic [CNT_W-1:0] LAST_CLS = CNT_W'(NUM_CLASSES - 1);

  logic [1:0]            state_q,      state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [PROB_BITS-1:0]  thr_q,        thr_d;
  logic [31:0]           buf_q,        buf_d;
  logic [CNT_W-1:0]      cls_q,        cls_d;
  logic [PROB_BITS-1:0]  max_val_q,    max_val_d;
  logic [CNT_W-1:0]      max_idx_q,    max_idx_d;
  logic [IDX_BITS-1:0]   class_idx_q,  class_idx_d;
  logic [PROB_BITS-1:0]  class_prob_q, class_prob_d;
  logic                  detected_q,   detected_d;
  logic                  done_q,       done_d;

  logic [PROB_BITS-1:0]  cur_byte;
  logic [PROB_BITS-1:0]  new_val;
  logic [CNT_W-1:0]      new_idx;

  // Next-state logic: start acceptance, word fetch, byte-serial compare, result capture.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    thr_d        = thr_q;
    buf_d        = buf_q;
    cls_d        = cls_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    class_idx_d  = class_idx_q;
    class_prob_d = class_prob_q;
    detected_d   = detected_q;
    done_d       = 1'b0;
    cur_byte     = buf_q[{cls_q[1:0], 3'b000} +: PROB_BITS];
    new_val      = max_val_q;
    new_idx      = max_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d = base_addr;
          thr_d      = threshold;
          max_val_d  = '0;
          max_idx_d  = '0;
          cls_d      = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_done) begin
          buf_d   = mem_rdata;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare: ties keep the earlier (lower) class index.
        if (cur_byte > max_val_q) begin
          new_val = cur_byte;
          new_idx = cls_q;
        end
        max_val_d = new_val;
        max_idx_d = new_idx;
        if (cls_q == LAST_CLS) begin
          // Results are registered on entry so they are valid during the done cycle.
          class_idx_d  = IDX_BITS'(new_idx);
          class_prob_d = new_val;
          detected_d   = (new_val >= thr_q);
          done_d       = 1'b1;
          state_d      = S_FINISH;
        end else begin
          cls_d = cls_q + CNT_W'(1);
          if (cls_q[1:0] == 2'd3) begin
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(4);
            state_d    = S_REQ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      thr_q        <= '0;
      buf_q        <= '0;
      cls_q        <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      class_idx_q  <= '0;
      class_prob_q <= '0;
      detected_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      thr_q        <= thr_d;
      buf_q        <= buf_d;
      cls_q        <= cls_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      class_idx_q  <= class_idx_d;
      class_prob_q <= class_prob_d;
      detected_q   <= detected_d;
      done_q       <= done_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_size   = 3'd4;
  assign mem_start  = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign class_idx  = class_idx_q;
  assign class_prob = class_prob_q;
  assign detected   = detected_q;
  assign dbg_state  = state_q;

endmodule
